// File: rtl/resource_rr_arbiter_if.sv
// Bundle of request/grant/handshake signals between the requesting units,
// the shared resource and resource_rr_arbiter.
interface resource_rr_arbiter_if #(
  parameter int NUM_REQUESTERS = 4
);
  logic [NUM_REQUESTERS-1:0] req;
  logic                      resource_ready;
  logic                      resource_done;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [31:0]               grant_index;
  logic                      grant_valid;
  logic                      timeout;

  modport master (
    output req, resource_ready, resource_done,
    input  grant, grant_index, grant_valid, timeout
  );

  modport slave (
    input  req, resource_ready, resource_done,
    output grant, grant_index, grant_valid, timeout
  );
endinterface

// File: rtl/resource_rr_arbiter.sv
// Round-robin arbiter for one shared resource with grant/accept/release handshake.
// Optional BUSY watchdog enabled by defining RR_ARBITER_TIMEOUT_EN.
module resource_rr_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        reset_n,
  resource_rr_arbiter_if.slave        bus
);

  localparam logic [31:0] N_U = 32'(NUM_REQUESTERS);

  if (NUM_REQUESTERS < 1 || NUM_REQUESTERS > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("resource_rr_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY
  } state_t;

  state_t                    state_q, state_d;
  logic [31:0]               ptr_q, ptr_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [31:0]               grant_index_q, grant_index_d;
  logic                      grant_valid_q, grant_valid_d;
  logic                      timeout_q, timeout_d;
`ifdef RR_ARBITER_TIMEOUT_EN
  logic [31:0]               wd_cnt_q, wd_cnt_d;
`endif

  logic [NUM_REQUESTERS-1:0] req_rot;
  logic [31:0]               rot_first;
  logic [31:0]               winner;
  logic [NUM_REQUESTERS-1:0] winner_oh;
  logic [31:0]               ptr_after_owner;
  logic                      owner_req;

  function automatic logic [31:0] find_first_one_index(input logic [NUM_REQUESTERS-1:0] vec);
    logic [31:0] idx;
    logic        found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (vec[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Rotating by ptr puts the highest-priority requester at bit 0.
  always_comb begin
    req_rot   = NUM_REQUESTERS'({bus.req, bus.req} >> ptr_q);
    rot_first = find_first_one_index(req_rot);
    winner    = ptr_q + rot_first;
    if (winner >= N_U) begin
      winner = winner - N_U;
    end
    winner_oh = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      winner_oh[i] = (winner == i);
    end
  end

  always_comb begin
    ptr_after_owner = (grant_index_q == N_U - 32'd1) ? '0 : grant_index_q + 32'd1;
    // grant_q is one-hot on the owner, so this is req[grant_index].
    owner_req       = |(bus.req & grant_q);
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_index_d = grant_index_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d       = ST_GRANT;
          grant_d       = winner_oh;
          grant_index_d = winner;
          grant_valid_d = 1'b1;
        end
      end

      ST_GRANT: begin
        if (bus.resource_ready) begin
          state_d       = ST_BUSY;
          grant_valid_d = 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
          wd_cnt_d      = '0;
`endif
        end else if (!owner_req) begin
          state_d       = ST_IDLE;
          grant_d       = '0;
          grant_index_d = '0;
          grant_valid_d = 1'b0;
        end
      end

      ST_BUSY: begin
        if (bus.resource_done) begin
          state_d       = ST_IDLE;
          grant_d       = '0;
          grant_index_d = '0;
          ptr_d         = ptr_after_owner;
`ifdef RR_ARBITER_TIMEOUT_EN
        end else if (wd_cnt_q + 32'd1 >= 32'(TIMEOUT_CYCLES)) begin
          // Watchdog expiry releases exactly like resource_done, plus a pulse.
          state_d       = ST_IDLE;
          grant_d       = '0;
          grant_index_d = '0;
          grant_valid_d = 1'b0;
          ptr_d         = ptr_after_owner;
          timeout_d     = 1'b1;
          wd_cnt_d      = '0;
        end else begin
          wd_cnt_d      = wd_cnt_q + 32'd1;
`endif
        end
      end

      default: begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        grant_index_d = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_index_q <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
      wd_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_index_q <= grant_index_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
`ifdef RR_ARBITER_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_index = grant_index_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: doc/resource_rr_arbiter.md
# resource_rr_arbiter

Round-robin arbiter granting a single shared pipeline resource (e.g. one register-file write port or one memory request channel) to one of NUM_REQUESTERS requesters. Rotates the request vector by a fairness pointer, selects the winner with the existing find_first_one_index priority encoder, then runs a grant/accept/release handshake. Sits between the requesting units and the shared resource; owns the grant until the resource signals completion.

## Interface

- NUM_REQUESTERS, default 4: number of requesters, legal range 1..32.
- TIMEOUT_CYCLES, default 256: BUSY-state watchdog limit; used only when the Configuration macro is defined.
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- req  input  NUM_REQUESTERS  per-requester request level.
- resource_ready  input  1  resource accepts the offered grant.
- resource_done  input  1  resource finished the granted transaction; single-cycle pulse.
- grant  output  NUM_REQUESTERS  one-hot owner vector, registered.
- grant_index  output  32  binary index of the owner, registered.
- grant_valid  output  1  grant is being offered to the resource, registered.
- timeout  output  1  single-cycle watchdog pulse, registered.

## Operation

- State machine: IDLE, GRANT, BUSY. Fairness pointer ptr ranges 0..NUM_REQUESTERS-1.
- Winner computation, combinational: rotate req right by ptr; find_first_one_index returns the lowest set bit index r; winner = (ptr + r) mod NUM_REQUESTERS. Result is used only when req is non-zero; the encoder output for an all-zero vector is ignored.
- IDLE: on posedge with req non-zero, latch the winner into grant and grant_index, set grant_valid=1, and go to GRANT. With req all-zero, stay in IDLE.
- GRANT:
  - resource_ready=1: go to BUSY and clear grant_valid. grant and grant_index hold.
  - resource_ready=0 and req[grant_index]=0 (requester withdrew): go to IDLE; clear grant, grant_index and grant_valid; ptr unchanged.
  - Otherwise hold.
  - resource_done is ignored in GRANT.
  - resource_ready=1 together with a withdrawn req: ready wins; go to BUSY.
- BUSY: on resource_done=1, go to IDLE, clear grant and grant_index, and set ptr = (grant_index+1) mod NUM_REQUESTERS. req changes are ignored in BUSY.
- Winner selection ignores requests arriving during GRANT or BUSY; they are served in later IDLE arbitrations.
- NUM_REQUESTERS=1: ptr is always 0 and the single requester is always the winner.

## Timing

- Reset values: state=IDLE, ptr=0, grant=0, grant_index=0, grant_valid=0, timeout=0, watchdog count=0. Reset takes effect from any state, including mid-BUSY; it takes precedence over all inputs on the same edge.
- Latency: req sampled at edge T produces grant/grant_valid visible after edge T.
- Handshake: accepted at the first edge with grant_valid=1 and resource_ready=1. grant_valid is low from the cycle after acceptance.
- Release: resource_done at edge D puts the block in IDLE after D. The earliest next grant is after edge D+1, so there is one idle cycle between owners.
- Pointer update happens only on release, never on withdrawal.

## Configuration

- Macro RR_ARBITER_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to BUSY and increments each BUSY cycle without resource_done.
  - When the count reaches TIMEOUT_CYCLES: force IDLE, clear grant, grant_index and grant_valid, advance ptr exactly as on a release, and drive timeout=1 for one cycle.
  - resource_done on the same edge takes precedence: normal release, no timeout pulse.
- Undefined: no counter; timeout is tied to 0; BUSY waits for resource_done indefinitely.

## Test plan

- Reset: hold reset_n=0 for 3 cycles with req=4'b1111 -> grant=0, grant_index=0, grant_valid=0, timeout=0 throughout. Repeat by asserting reset_n=0 during BUSY -> all outputs return to these values after the next edge; the next grant goes to index 0.
- Basic rotation (NUM_REQUESTERS=4): req=4'b0101, ptr=0 -> grant=4'b0001, grant_index=0. After ready and done -> ptr=1, next grant_index=2.
- Full load: req=4'b1111 held, with ready one cycle after grant and done one cycle after accept -> grant_index sequence 0,1,2,3,0, with one idle cycle between owners.
- Withdrawal: req=4'b0100 -> grant_index=2. Drop req[2] while resource_ready=0 -> grant_valid=0 after the next edge and ptr stays 0. Then req=4'b0110 -> grant_index=1.
- Simultaneous events: in GRANT, apply resource_ready=1, resource_done=1 and req[owner]=0 on the same edge -> BUSY, grant held. A later done releases.
- Timeout (RR_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8): accept a grant and never pulse done -> timeout=1 for exactly one cycle after the 8th BUSY cycle, grant cleared, ptr advanced. With the macro undefined -> grant held after 100 cycles and timeout stays 0.
